// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache front-end: refill FSM states
// and the address-field width helpers used by the fetch-stage modules.
package icache_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } state_t;

   // Byte offset inside a 32-bit word; always dropped from fetch addresses.
   localparam int BYTE_W = 2;

   // Word-offset field width for a line of 'words' 32-bit words.
   function automatic int off_w(input int words);
      return $clog2(words);
   endfunction

   // Line-index field width for a cache of 'lines' lines.
   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Tag field width: whatever is left of the byte address above index/offset.
   function automatic int tag_w(input int addr_w, input int lines, input int words);
      return addr_w - $clog2(lines) - $clog2(words) - BYTE_W;
   endfunction

endpackage : icache_pkg

// File: rtl/icache_refill_ctrl.sv
// Refill controller: walks one cache line word-by-word over the backing-memory
// req/valid handshake and produces the write strobes for the tag/data arrays.
module icache_refill_ctrl
   import icache_pkg::*;
#(
   parameter  int ADDR_W = 32,
   parameter  int LINES  = 16,
   parameter  int WORDS  = 4,
   localparam int OFF_W  = off_w(WORDS),
   localparam int IDX_W  = idx_w(LINES),
   localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS),
   localparam int LINE_W = TAG_W + IDX_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic [LINE_W-1:0] start_line,
   input  logic              Flush,
   input  logic              Mem_Valid,
   output logic              busy,
   output logic              Mem_Req,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic              wr_en,
   output logic [IDX_W-1:0]  wr_idx,
   output logic [OFF_W-1:0]  wr_off,
   output logic [TAG_W-1:0]  wr_tag,
   output logic              fill_done,
   output logic              fill_valid
);

   state_t            state_q, state_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              drop_q, drop_d;
   logic              last_word;

   assign last_word = (cnt_q == OFF_W'(WORDS - 1));

   // State register: synchronous reset abandons any refill in flight.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         drop_q  <= drop_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      line_d     = line_q;
      drop_d     = drop_q;
      busy       = 1'b0;
      Mem_Req    = 1'b0;
      Mem_Addr   = '0;
      wr_en      = 1'b0;
      fill_done  = 1'b0;
      fill_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = REFILL;
               line_d  = start_line;
               cnt_d   = '0;
               drop_d  = 1'b0;
            end
         end
         REFILL: begin
            busy     = 1'b1;
            Mem_Req  = 1'b1;
            Mem_Addr = {line_q, cnt_q, 2'b00};
            if (Flush) drop_d = 1'b1;
            if (Mem_Valid) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (last_word) begin
                  fill_done = 1'b1;
                  // A flush landing on the final word also leaves the line invalid.
                  fill_valid = ~drop_q & ~Flush;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_idx = line_q[IDX_W-1:0];
   assign wr_tag = line_q[LINE_W-1 -: TAG_W];
   assign wr_off = cnt_q;

endmodule : icache_refill_ctrl

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: combinational hit path into the fetch stage,
// Imiss stall while a line is refilled from the backing memory.
module inst_cache
   import icache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINES  = 16,
   parameter int WORDS  = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              En,
   input  logic [ADDR_W-1:0] Addr,
   input  logic              Flush,
   output logic [31:0]       Data,
   output logic              Imiss,
   output logic              Mem_Req,
   output logic [ADDR_W-1:0] Mem_Addr,
   input  logic [31:0]       Mem_Rdata,
   input  logic              Mem_Valid
);

   localparam int OFF_W = off_w(WORDS);
   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);

   logic [TAG_W-1:0] tag;
   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] off;
   logic             addr_unused;

   logic [31:0]      data_q [LINES][WORDS];
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [LINES-1:0] valid_q;
   logic [31:0]      last_q;

   logic             hit;
   logic             busy;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [OFF_W-1:0] wr_off;
   logic [TAG_W-1:0] wr_tag;
   logic             fill_done;
   logic             fill_valid;

   assign tag         = Addr[ADDR_W-1 -: TAG_W];
   assign idx         = Addr[IDX_W+OFF_W+1 : OFF_W+2];
   assign off         = Addr[OFF_W+1 : 2];
   assign addr_unused = ^Addr[1:0];

   // Lookups are only honoured while no refill is in flight.
   assign hit   = En & valid_q[idx] & (tag_q[idx] == tag) & ~busy;
   assign Imiss = En & ~hit;
   assign Data  = Rst ? 32'h0 : (hit ? data_q[idx][off] : last_q);

   icache_refill_ctrl #(
      .ADDR_W (ADDR_W),
      .LINES  (LINES),
      .WORDS  (WORDS)
   ) u_refill (
      .Clk        (Clk),
      .Rst        (Rst),
      .start      (En & ~hit & ~Flush),
      .start_line ({tag, idx}),
      .Flush      (Flush),
      .Mem_Valid  (Mem_Valid),
      .busy       (busy),
      .Mem_Req    (Mem_Req),
      .Mem_Addr   (Mem_Addr),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_off     (wr_off),
      .wr_tag     (wr_tag),
      .fill_done  (fill_done),
      .fill_valid (fill_valid)
   );

   // Valid bits: cleared by reset or flush, set when a line finishes filling.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         valid_q <= '0;
      end else begin
         if (Flush) valid_q <= '0;
         if (fill_done) valid_q[wr_idx] <= fill_valid;
      end
   end

   // Tag and data arrays written by the refill controller.
   always_ff @(posedge Clk) begin
      // NOTE: the arrays carry no reset; a line is never read before its valid
      // bit is set, and leaving them unreset lets them map onto RAM.
      if (wr_en) data_q[wr_idx][wr_off] <= Mem_Rdata;
      if (fill_done) tag_q[wr_idx] <= wr_tag;
   end

   // Output holding register so Data stays put on misses and idle cycles.
   always_ff @(posedge Clk) begin
      if (Rst) last_q <= '0;
      else     last_q <= Data;
   end

endmodule : inst_cache

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache (LINES=4, WORDS=4): directed scenarios
// followed by random fetches, scored against a line-level cache model.
module tb_inst_cache;

   localparam logic [31:0] KEY   = 32'hA5A5_0000;
   localparam int          BOUND = 200;

   logic        Clk = 1'b0;
   logic        Rst, En, Flush, Mem_Valid;
   logic [31:0] Addr, Mem_Rdata;
   logic [31:0] Data, Mem_Addr;
   logic        Imiss, Mem_Req;

   typedef struct {
      logic [31:0] addr;
      bit          hit;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] maddr_q[$];
   bit          mv[4];
   logic [31:0] mtag[4];
   int          tests = 0, fails = 0;
   int          cyc = 0, last_mv = -10;

   inst_cache #(.ADDR_W(32), .LINES(4), .WORDS(4)) dut (
      .Clk(Clk), .Rst(Rst), .En(En), .Addr(Addr), .Flush(Flush),
      .Data(Data), .Imiss(Imiss), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
      .Mem_Rdata(Mem_Rdata), .Mem_Valid(Mem_Valid)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
   endtask

   function automatic bit model_hit(input logic [31:0] a);
      return mv[a[5:4]] && (mtag[a[5:4]] == (a >> 6));
   endfunction

   task automatic push_line(input logic [31:0] a);
      for (int k = 0; k < 4; k++) maddr_q.push_back({a[31:4], 4'h0} + 32'(k * 4));
   endtask

   // Cycle counter; remembers the cycle in which the last Mem_Valid pulse sat.
   initial begin
      forever begin
         @(posedge Clk);
         if (Mem_Valid) last_mv = cyc;
         cyc++;
      end
   end

   // Backing memory: answers each request two cycles after it is seen.
   initial begin
      int wait_cnt = 0;
      Mem_Valid = 1'b0;
      Mem_Rdata = '0;
      forever begin
         @(negedge Clk);
         if (Rst) begin
            Mem_Valid = 1'b0;
            wait_cnt  = 0;
         end else if (Mem_Valid) begin
            Mem_Valid = 1'b0;
            wait_cnt  = 0;
         end else if (Mem_Req) begin
            wait_cnt++;
            if (wait_cnt == 2) begin
               if (maddr_q.size() == 0) check("mem_req_expected", 32'(maddr_q.size()), 32'd1);
               else check("mem_addr_order", Mem_Addr, maddr_q.pop_front());
               Mem_Rdata = Mem_Addr ^ KEY;
               Mem_Valid = 1'b1;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Monitor: scores every served fetch and the hold rules on other cycles.
   initial begin
      logic [31:0] prev = '0;
      bit          saw_miss = 1'b0;
      exp_t        e;
      forever begin
         @(negedge Clk);
         if (Rst) begin
            saw_miss = 1'b0;
         end else begin
            if (!Mem_Req) check("mem_addr_when_idle", Mem_Addr, 32'h0);
            if (En && Imiss) begin
               saw_miss = 1'b1;
               check("data_hold_miss", Data, prev);
            end else if (En) begin
               if (exp_q.size() == 0) begin
                  check("fetch_expected", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("fetch_data", Data, e.addr ^ KEY);
                  check("miss_seen", 32'(saw_miss), 32'(!e.hit));
                  check("mem_req_on_hit", 32'(Mem_Req), 32'd0);
                  if (saw_miss) check("miss_to_hit_cycle", 32'(cyc), 32'(last_mv + 1));
               end
               saw_miss = 1'b0;
            end else begin
               check("imiss_when_idle", 32'(Imiss), 32'd0);
               check("data_hold_idle", Data, prev);
            end
         end
         prev = Data;
      end
   end

   // Issue one fetch and hold it until served.
   task automatic fetch(input logic [31:0] a);
      exp_t e;
      int   n = 0;
      e.addr = {a[31:2], 2'b00};
      e.hit  = model_hit(e.addr);
      exp_q.push_back(e);
      if (!e.hit) push_line(e.addr);
      En   = 1'b1;
      Addr = a;
      forever begin
         @(negedge Clk);
         if (!Imiss) break;
         if (++n > BOUND) begin
            check("fetch_served", 32'(Imiss), 32'd0);
            break;
         end
      end
      mv[e.addr[5:4]]   = 1'b1;
      mtag[e.addr[5:4]] = e.addr >> 6;
      @(posedge Clk); #1;
   endtask

   // Missing fetch with Flush raised on the 2nd Mem_Valid: the refill runs out
   // but leaves the line invalid, so the held address misses and refills again.
   task automatic fetch_flush(input logic [31:0] a);
      exp_t e;
      int   n = 0, mvc = 0;
      bit   flushed = 1'b0;
      e.addr = {a[31:2], 2'b00};
      e.hit  = 1'b0;
      exp_q.push_back(e);
      push_line(e.addr);
      push_line(e.addr);
      En   = 1'b1;
      Addr = a;
      forever begin
         @(negedge Clk);
         if (!Imiss) break;
         if (++n > BOUND) begin
            check("flush_fetch_served", 32'(Imiss), 32'd0);
            break;
         end
         #2;
         if (Mem_Valid && !flushed) begin
            mvc++;
            if (mvc == 2) begin
               Flush   = 1'b1;
               flushed = 1'b1;
               model_clear();
               @(posedge Clk); #1;
               Flush = 1'b0;
            end
         end
      end
      mv[e.addr[5:4]]   = 1'b1;
      mtag[e.addr[5:4]] = e.addr >> 6;
      @(posedge Clk); #1;
   endtask

   // Reset asserted after the first word of a refill has been delivered.
   task automatic rst_mid(input logic [31:0] a);
      int n = 0;
      push_line(a);
      En   = 1'b1;
      Addr = a;
      forever begin
         @(negedge Clk); #2;
         if (Mem_Valid) break;
         if (++n > BOUND) begin
            check("rst_mid_first_word", 32'(Mem_Valid), 32'd1);
            break;
         end
      end
      @(posedge Clk); #1;
      Rst = 1'b1;
      maddr_q.delete();
      model_clear();
      @(negedge Clk);
      check("rst_data", Data, 32'h0);
      check("rst_imiss", 32'(Imiss), 32'd1);
      @(posedge Clk); #1;
      check("rst_mem_req", 32'(Mem_Req), 32'd0);
      check("rst_mem_addr", Mem_Addr, 32'h0);
      Rst = 1'b0;
      En  = 1'b0;
   endtask

   task automatic idle(input int n);
      En = 1'b0;
      repeat (n) begin
         @(negedge Clk);
         check("idle_mem_req", 32'(Mem_Req), 32'd0);
         @(posedge Clk); #1;
      end
   endtask

   task automatic flush_idle();
      En    = 1'b0;
      Flush = 1'b1;
      model_clear();
      @(posedge Clk); #1;
      Flush = 1'b0;
   endtask

   // Stimulus.
   initial begin
      int r;
      Rst   = 1'b1;
      En    = 1'b1;
      Addr  = '0;
      Flush = 1'b0;
      model_clear();
      @(posedge Clk); #1;
      @(negedge Clk);
      check("reset_data", Data, 32'h0);
      check("reset_imiss", 32'(Imiss), 32'd1);
      check("reset_mem_req", 32'(Mem_Req), 32'd0);
      check("reset_mem_addr", Mem_Addr, 32'h0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      En  = 1'b0;
      @(posedge Clk); #1;

      fetch(32'h40);                       // cold miss
      fetch(32'h44);                       // back-to-back hits
      fetch(32'h48);
      fetch(32'h4C);
      fetch(32'h80);                       // conflict on index 0
      fetch(32'h40);
      fetch_flush(32'h100);                // flush mid-refill
      fetch(32'h40);
      idle(3);                             // hold after a hit
      rst_mid(32'h180);                    // reset mid-refill
      fetch(32'h40);
      fetch(32'h50);
      fetch(32'h60);
      fetch(32'h70);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r == 7)      idle($urandom_range(1, 2));
         else if (r == 8) flush_idle();
         else             fetch(32'($urandom_range(0, 127)) << 2);
      end

      idle(4);
      check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
      check("mem_queue_drained", 32'(maddr_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule : tb_inst_cache
